// File: rtl/ram_arbiter.sv
// Shared system-RAM arbiter between a CPU port and a video read port.
// One grant per cycle, registered RAM command, reads returned three cycles after the grant.
module ram_arbiter #(
    parameter logic [14:0] ROM_TOP    = 15'h1000,
    parameter int          STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [14:0] cpu_add,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    output logic        rom_wr_err,
    input  logic        vid_req,
    input  logic [14:0] vid_add,
    output logic        vid_ack,
    output logic [7:0]  vid_rdata,
    output logic        vid_rvalid,
    output logic [14:0] ram_add,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout
);

    localparam int SW = (STARVE_MAX < 4) ? 2 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic          cpuWin;
    logic          vidWin;
    logic [SW-1:0] starve_d;
    logic [SW-1:0] starve_q;

    logic          cpuAck_q;
    logic          vidAck_q;
    logic          romErr_q;
    logic          ramWe_q;
    logic [14:0]   ramAdd_q;
    logic [7:0]    ramDin_q;

    // Owner pipeline: stage 1 lines up with the RAM command, stage 2 with ram_dout.
    logic          rdValid1_q;
    logic          rdOwnCpu1_q;
    logic          rdValid2_q;
    logic          rdOwnCpu2_q;

    logic          cpuRvalid_q;
    logic          vidRvalid_q;
    logic [7:0]    cpuRdata_q;
    logic [7:0]    vidRdata_q;

    // Video normally wins a tie; a CPU that has waited STARVE_MAX video grants wins instead.
    always_comb begin
        cpuWin   = 1'b0;
        vidWin   = 1'b0;
        starve_d = starve_q;
        if (cpu_req && vid_req) begin
            cpuWin = (starve_q == STARVE_LIM);
            vidWin = !cpuWin;
        end else begin
            cpuWin = cpu_req;
            vidWin = vid_req;
        end
        if (!cpu_req || cpuWin) begin
            starve_d = '0;
        end else if (vidWin && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q    <= '0;
            cpuAck_q    <= 1'b0;
            vidAck_q    <= 1'b0;
            romErr_q    <= 1'b0;
            ramWe_q     <= 1'b0;
            ramAdd_q    <= '0;
            ramDin_q    <= '0;
            rdValid1_q  <= 1'b0;
            rdOwnCpu1_q <= 1'b0;
            rdValid2_q  <= 1'b0;
            rdOwnCpu2_q <= 1'b0;
            cpuRvalid_q <= 1'b0;
            vidRvalid_q <= 1'b0;
            cpuRdata_q  <= '0;
            vidRdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            cpuAck_q <= cpuWin;
            vidAck_q <= vidWin;
            romErr_q <= cpuWin && cpu_we && (cpu_add < ROM_TOP);
            ramWe_q  <= cpuWin && cpu_we && (cpu_add >= ROM_TOP);

            if (cpuWin) begin
                ramAdd_q <= cpu_add;
                ramDin_q <= cpu_wdata;
            end else if (vidWin) begin
                ramAdd_q <= vid_add;
            end

            rdValid1_q  <= vidWin || (cpuWin && !cpu_we);
            rdOwnCpu1_q <= cpuWin;
            rdValid2_q  <= rdValid1_q;
            rdOwnCpu2_q <= rdOwnCpu1_q;

            cpuRvalid_q <= rdValid2_q && rdOwnCpu2_q;
            vidRvalid_q <= rdValid2_q && !rdOwnCpu2_q;
            if (rdValid2_q && rdOwnCpu2_q) begin
                cpuRdata_q <= ram_dout;
            end
            if (rdValid2_q && !rdOwnCpu2_q) begin
                vidRdata_q <= ram_dout;
            end
        end
    end

    assign cpu_ack    = cpuAck_q;
    assign vid_ack    = vidAck_q;
    assign rom_wr_err = romErr_q;
    assign ram_we     = ramWe_q;
    assign ram_add    = ramAdd_q;
    assign ram_din    = ramDin_q;
    assign cpu_rvalid = cpuRvalid_q;
    assign vid_rvalid = vidRvalid_q;
    assign cpu_rdata  = cpuRdata_q;
    assign vid_rdata  = vidRdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a cycle-level reference model queues expected acks
// and read returns, and an independent monitor matches them against what the DUT shows.
module tb_ram_arbiter;

    localparam logic [14:0] ROM_TOP    = 15'h1000;
    localparam int          STARVE_MAX = 3;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [14:0] cpu_add;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        rom_wr_err;
    logic        vid_req;
    logic [14:0] vid_add;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic        vid_rvalid;
    logic [14:0] ram_add;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ramDout;

    ram_arbiter #(.ROM_TOP(ROM_TOP), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_add(cpu_add), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .rom_wr_err(rom_wr_err),
        .vid_req(vid_req), .vid_add(vid_add), .vid_ack(vid_ack),
        .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .ram_add(ram_add), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ramDout)
    );

    typedef struct {
        int          due;
        bit          isCpu;
        bit          we;
        bit          err;
        logic [14:0] add;
        logic [7:0]  din;
    } ackExp_t;

    typedef struct {
        int         due;
        bit         isCpu;
        logic [7:0] data;
    } rdExp_t;

    ackExp_t     ackQ[$];
    rdExp_t      rdQ[$];
    bit          grantLog[$];
    bit          logOn;
    bit          monitorOn;
    bit          preload;
    int          cycle;
    int          checks;
    int          errors;
    int          starve;
    logic [14:0] modelAdd;
    logic [7:0]  lastCpuData;
    logic [7:0]  lastVidData;
    logic [7:0]  refMem [0:32767];
    logic [7:0]  ramMem [0:32767];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [7:0] initByte(input int a);
        logic [14:0] x;
        x = a[14:0];
        if (x == 15'h1234) return 8'hA5;
        return x[7:0] ^ x[14:7];
    endfunction

    // RAM with a registered, read-first output port
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32768; i++) ramMem[i] <= initByte(i);
            ramDout <= 8'h00;
        end else begin
            if (ram_we) ramMem[ram_add] <= ram_din;
            ramDout <= ramMem[ram_add];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Drives one cycle of requests and records what the arbiter must answer.
    task automatic applyStimulus(input bit cReq, input logic [14:0] cAdd, input bit cWe,
                                 input logic [7:0] cData, input bit vReq, input logic [14:0] vAdd);
        bit      cpuGo;
        bit      vidGo;
        ackExp_t a;
        rdExp_t  r;
        @(negedge clk);
        cpu_req   = cReq;
        cpu_add   = cAdd;
        cpu_we    = cWe;
        cpu_wdata = cData;
        vid_req   = vReq;
        vid_add   = vAdd;
        if (cReq && vReq) begin
            cpuGo = (starve == STARVE_MAX);
            vidGo = !cpuGo;
        end else begin
            cpuGo = cReq;
            vidGo = vReq;
        end
        if (!cReq || cpuGo) starve = 0;
        else if (vidGo && starve < STARVE_MAX) starve++;
        a.due = cycle + 1;
        r.due = cycle + 3;
        if (cpuGo) begin
            a.isCpu = 1'b1;
            a.add   = cAdd;
            a.din   = cData;
            a.we    = cWe && (cAdd >= ROM_TOP);
            a.err   = cWe && (cAdd < ROM_TOP);
            ackQ.push_back(a);
            if (a.we) refMem[cAdd] = cData;
            if (!cWe) begin
                r.isCpu = 1'b1;
                r.data  = refMem[cAdd];
                rdQ.push_back(r);
            end
        end else if (vidGo) begin
            a.isCpu = 1'b0;
            a.add   = vAdd;
            a.din   = 8'h00;
            a.we    = 1'b0;
            a.err   = 1'b0;
            ackQ.push_back(a);
            r.isCpu = 1'b0;
            r.data  = refMem[vAdd];
            rdQ.push_back(r);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, cpu_add, 0, 8'h00, 0, vid_add);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cpu_ack"}, cpu_ack, 0);
        checkOutput({tag, "_vid_ack"}, vid_ack, 0);
        checkOutput({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
        checkOutput({tag, "_vid_rvalid"}, vid_rvalid, 0);
        checkOutput({tag, "_rom_wr_err"}, rom_wr_err, 0);
        checkOutput({tag, "_ram_we"}, ram_we, 0);
        checkOutput({tag, "_ram_add"}, ram_add, 0);
        checkOutput({tag, "_ram_din"}, ram_din, 0);
        checkOutput({tag, "_cpu_rdata"}, cpu_rdata, 0);
        checkOutput({tag, "_vid_rdata"}, vid_rdata, 0);
    endtask

    task automatic resetModel();
        ackQ.delete();
        rdQ.delete();
        starve      = 0;
        modelAdd    = '0;
        lastCpuData = '0;
        lastVidData = '0;
    endtask

    // Monitor: pops an expectation whenever the DUT presents an ack or read return
    always @(negedge clk) begin
        if (monitorOn && !reset) begin
            checkOutput("single_grant", {31'd0, cpu_ack & vid_ack}, 0);
            checkOutput("single_rvalid", {31'd0, cpu_rvalid & vid_rvalid}, 0);
            if (cpu_ack || vid_ack) begin
                if (ackQ.size() == 0) begin
                    checkOutput("unexpected_ack", {30'd0, cpu_ack, vid_ack}, 0);
                end else begin
                    ackExp_t e;
                    e = ackQ.pop_front();
                    checkOutput("ack_cycle", cycle, e.due);
                    checkOutput("ack_port_cpu", {31'd0, cpu_ack}, {31'd0, e.isCpu});
                    checkOutput("rom_wr_err", {31'd0, rom_wr_err}, {31'd0, e.err});
                    checkOutput("ram_we", {31'd0, ram_we}, {31'd0, e.we});
                    checkOutput("ram_add", {17'd0, ram_add}, {17'd0, e.add});
                    if (e.we) checkOutput("ram_din", {24'd0, ram_din}, {24'd0, e.din});
                    modelAdd = e.add;
                    if (logOn) grantLog.push_back(cpu_ack);
                end
            end else begin
                checkOutput("idle_ram_we", {31'd0, ram_we}, 0);
                checkOutput("idle_rom_wr_err", {31'd0, rom_wr_err}, 0);
                checkOutput("idle_ram_add", {17'd0, ram_add}, {17'd0, modelAdd});
                if (ackQ.size() > 0 && ackQ[0].due < cycle) begin
                    checkOutput("ack_missing_due", cycle, ackQ[0].due);
                    void'(ackQ.pop_front());
                end
            end
            if (cpu_rvalid || vid_rvalid) begin
                if (rdQ.size() == 0) begin
                    checkOutput("unexpected_rvalid", {30'd0, cpu_rvalid, vid_rvalid}, 0);
                end else begin
                    rdExp_t r;
                    r = rdQ.pop_front();
                    checkOutput("rvalid_cycle", cycle, r.due);
                    checkOutput("rvalid_port_cpu", {31'd0, cpu_rvalid}, {31'd0, r.isCpu});
                    if (r.isCpu) lastCpuData = r.data;
                    else lastVidData = r.data;
                end
            end else if (rdQ.size() > 0 && rdQ[0].due < cycle) begin
                checkOutput("rvalid_missing_due", cycle, rdQ[0].due);
                void'(rdQ.pop_front());
            end
            checkOutput("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, lastCpuData});
            checkOutput("vid_rdata", {24'd0, vid_rdata}, {24'd0, lastVidData});
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        cycle     = 0;
        logOn     = 0;
        monitorOn = 0;
        preload   = 1;
        reset     = 0;
        cpu_req   = 0;
        cpu_add   = '0;
        cpu_we    = 0;
        cpu_wdata = '0;
        vid_req   = 0;
        vid_add   = '0;
        for (int i = 0; i < 32768; i++) refMem[i] = initByte(i);
        resetModel();
        #1 reset = 1;
        repeat (2) @(negedge clk);
        preload = 0;
        checkAllZero("reset");
        reset     = 0;
        monitorOn = 1;

        $display("[TB] CPU read, write, ROM-protected write");
        applyStimulus(1, 15'h1234, 0, 8'h00, 0, 15'h0);
        idle(4);
        applyStimulus(1, 15'h2000, 1, 8'h3C, 0, 15'h0);
        applyStimulus(1, 15'h2000, 0, 8'h00, 0, 15'h0);
        applyStimulus(1, 15'h0800, 1, 8'h55, 0, 15'h0);
        applyStimulus(1, 15'h0800, 0, 8'h00, 0, 15'h0);
        idle(4);
        checkOutput("ram_0800_untouched", {24'd0, refMem[15'h0800]}, {24'd0, initByte(32'h0800)});

        $display("[TB] Both requesters held continuously");
        logOn = 1;
        for (int i = 0; i < 16; i++) applyStimulus(1, 15'h3000, 0, 8'h00, 1, 15'h4000);
        idle(4);
        logOn = 0;
        checkOutput("grant_log_len", grantLog.size(), 16);
        for (int i = 0; i < 16 && i < grantLog.size(); i++)
            checkOutput("grant_pattern_cpu", {31'd0, grantLog[i]}, ((i % 4) == 3) ? 1 : 0);

        $display("[TB] Alternating video/CPU reads");
        for (int i = 0; i < 8; i++) begin
            if ((i % 2) == 0) applyStimulus(0, 15'h7001, 0, 8'h00, 1, 15'h7000);
            else applyStimulus(1, 15'h7001, 0, 8'h00, 0, 15'h7000);
        end
        idle(14);

        $display("[TB] Reset during an outstanding CPU read");
        applyStimulus(1, 15'h1234, 0, 8'h00, 0, 15'h0);
        cpu_req = 0;
        @(posedge clk);
        #2 reset = 1;
        #1 checkAllZero("midreset");
        resetModel();
        @(negedge clk);
        reset = 0;
        applyStimulus(1, 15'h2000, 0, 8'h00, 0, 15'h0);
        idle(5);

        $display("[TB] Randomized traffic");
        for (int i = 0; i < 300; i++) begin
            logic [14:0] ca;
            ca = ($urandom_range(0, 1) == 1) ? 15'(15'h0FF8 + 15'($urandom_range(0, 15)))
                                             : 15'($urandom);
            applyStimulus(($urandom % 3) != 0, ca, $urandom_range(0, 1) == 1, 8'($urandom),
                          $urandom_range(0, 1) == 1, 15'($urandom_range(15'h0FF8, 15'h1007)));
        end
        idle(6);
        checkOutput("ack_queue_drained", ackQ.size(), 0);
        checkOutput("rd_queue_drained", rdQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ROM_TOP, default 15'h1000, first writable address; CPU writes below it are blocked.
REQ-002 Parameter STARVE_MAX, default 3, maximum consecutive video grants while a CPU request waits.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU request, level, held with cpu_add/cpu_wdata/cpu_we stable until cpu_ack.
REQ-006 cpu_add  input  15  CPU byte address.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_we  input  1  1 = write, 0 = read.
REQ-009 cpu_ack  output  1  one-cycle pulse, request accepted.
REQ-010 cpu_rdata  output  8  CPU read data, valid while cpu_rvalid=1.
REQ-011 cpu_rvalid  output  1  one-cycle pulse, CPU read data returned.
REQ-012 rom_wr_err  output  1  one-cycle pulse, CPU write below ROM_TOP rejected.
REQ-013 vid_req  input  1  video read request, level, vid_add held stable until vid_ack.
REQ-014 vid_add  input  15  video read address (screen/font).
REQ-015 vid_ack  output  1  one-cycle pulse, video request accepted.
REQ-016 vid_rdata  output  8  video read data, valid while vid_rvalid=1.
REQ-017 vid_rvalid  output  1  one-cycle pulse, video read data returned.
REQ-018 ram_add  output  15  address to system RAM.
REQ-019 ram_din  output  8  write data to system RAM.
REQ-020 ram_we  output  1  write enable to system RAM.
REQ-021 ram_dout  input  8  system RAM read data, registered inside RAM, one-cycle latency.

Function
REQ-022 Arbitration in cycle N on sampled requests; winner's ram_add/ram_din/ram_we and its ack registered, valid throughout cycle N+1.
REQ-023 At most one grant per cycle; back-to-back grants in consecutive cycles supported (fully pipelined, no bubbles).
REQ-024 Priority: video wins when both request, except when starve counter equals STARVE_MAX, then CPU wins.
REQ-025 Starve counter (2 bits min): +1 on each video grant while cpu_req=1; cleared on CPU grant or when cpu_req=0; saturates at STARVE_MAX.
REQ-026 Only one requester active: that requester granted immediately, no counter effect beyond REQ-025.
REQ-027 No request: ram_we=0, ram_add/ram_din hold last value, no ack.
REQ-028 CPU write with cpu_add >= ROM_TOP: ram_we=1 in N+1, cpu_ack=1 in N+1, no rvalid.
REQ-029 CPU write with cpu_add < ROM_TOP: ram_we=0, cpu_ack=1 and rom_wr_err=1 in N+1, no rvalid.
REQ-030 Read latency: request granted in N, ram_dout captured at end of N+2 into *_rdata, *_rvalid=1 in cycle N+3 only.
REQ-031 Read-data routing via a 2-stage owner pipeline (valid + owner bit) so interleaved CPU/video reads return to correct port in grant order.
REQ-032 A requester holding req after its ack is treated as a new request (same address reread/rewritten).
REQ-033 cpu_rdata/vid_rdata hold last returned value between rvalid pulses.

Reset
REQ-034 While reset=1, immediately: all acks, rvalids, rom_wr_err, ram_we = 0; ram_add, ram_din, cpu_rdata, vid_rdata = 0; starve counter and owner pipeline cleared.
REQ-035 Reset mid-transaction discards in-flight reads (no rvalid after release); first grant possible in first cycle after reset deasserts.

Verification
REQ-036 CPU only: read 15'h1234 (RAM holds 8'hA5) -> cpu_ack in N+1, cpu_rvalid with cpu_rdata=8'hA5 in N+3.
REQ-037 CPU write 15'h2000=8'h3C then read -> ram_we=1 at 15'h2000, readback 8'h3C; write 15'h0800 -> ram_we=0, rom_wr_err pulse, RAM unchanged.
REQ-038 vid_req and cpu_req both held continuously -> grant pattern V,V,V,C repeating (STARVE_MAX=3).
REQ-039 Alternating granted reads video 15'h7000 / CPU 15'h7001 back-to-back -> rvalids alternate, each port receives its own byte, no bubbles.
REQ-040 Assert reset one cycle after CPU read grant -> all outputs 0 immediately, no cpu_rvalid afterwards; new request after release served normally.
REQ-041 No requests for 10 cycles -> ram_we=0, no acks, ram_add unchanged.
